ds1124_cmd_sequencer: RTL and testbench

DS1124_CMD_SEQUENCER -- requirements
Module: ds1124_cmd_sequencer

---
 rtl/ds1124_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ds1124_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds1124_cmd_sequencer.sv
//============================================================================
// Module      : ds1124_cmd_sequencer
// Description : Queues delay-code commands in a small FIFO and applies them
//               one at a time to a DS1124-style delay driver. Each write can
//               be read back and compared, with a bounded number of
//               rewrites. A watchdog abandons any handshake that stalls.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ds1124_cmd_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int VERIFY_EN   = 1,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_delay,
  output logic       cmd_ready,
  input  logic       drv_ready,
  output logic       drv_en,
  output logic [7:0] drv_delay,
  output logic       drv_read,
  input  logic [7:0] drv_rd_data,
  input  logic       drv_rd_valid,
  output logic       busy,
  output logic [7:0] applied_delay,
  output logic       applied_valid,
  output logic       err,
  output logic [7:0] err_count
);

  localparam int c_PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int c_TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRY);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_WR = 3'd1,
    S_WAIT_WR  = 3'd2,
    S_ISSUE_RD = 3'd3,
    S_WAIT_RD  = 3'd4,
    S_CHECK    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Command FIFO storage and bookkeeping
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  // Command in flight and handshake tracking
  logic [7:0]         r_cur_code;
  logic [c_RTY_W-1:0] r_retry_cnt;
  logic [c_TMO_W-1:0] r_tmo;
  logic               r_seen_low;
  logic               r_cap_done;
  logic [7:0]         r_rd_data;

  // Registered outputs
  logic               r_drv_en;
  logic               r_drv_read;
  logic [7:0]         r_applied_delay;
  logic               r_applied_valid;
  logic               r_err;
  logic [7:0]         r_err_count;

  // FSM decisions
  logic               w_issue_wr;
  logic               w_issue_rd;
  logic               w_apply;
  logic               w_fail;
  logic               w_retry;
  logic               w_timing;
  logic               w_state_chg;

  // A full FIFO refuses pushes even when a pop happens on the same edge.
  assign cmd_ready     = (r_count != c_FULL);
  assign w_push        = cmd_valid && cmd_ready;
  assign busy          = (r_count != '0) || (r_state != S_IDLE);

  assign drv_en        = r_drv_en;
  assign drv_read      = r_drv_read;
  assign drv_delay     = r_cur_code;
  assign applied_delay = r_applied_delay;
  assign applied_valid = r_applied_valid;
  assign err           = r_err;
  assign err_count     = r_err_count;

  assign w_timing    = (r_state == S_ISSUE_WR) || (r_state == S_WAIT_WR) ||
                       (r_state == S_ISSUE_RD) || (r_state == S_WAIT_RD);
  assign w_state_chg = (w_state_nxt != r_state);

  // FIFO data array; contents are don't-care while unoccupied, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cmd_delay;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and per-cycle decisions; the watchdog overrides any stalled wait
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue_wr  = 1'b0;
    w_issue_rd  = 1'b0;
    w_apply     = 1'b0;
    w_fail      = 1'b0;
    w_retry     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE_WR;
        end
      end
      S_ISSUE_WR: begin
        if (drv_ready) begin
          w_issue_wr  = 1'b1;
          w_state_nxt = S_WAIT_WR;
        end
      end
      S_WAIT_WR: begin
        // the driver must visibly go busy and then idle again
        if (r_seen_low && drv_ready) begin
          if (VERIFY_EN != 0) begin
            w_state_nxt = S_ISSUE_RD;
          end else begin
            w_apply     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_ISSUE_RD: begin
        if (drv_ready) begin
          w_issue_rd  = 1'b1;
          w_state_nxt = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        // readback may arrive before, during or after the busy window
        if ((r_cap_done || drv_rd_valid) && r_seen_low && drv_ready) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_rd_data == r_cur_code) begin
          w_apply     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_retry_cnt < c_RTY_MAX) begin
          w_retry     = 1'b1;
          w_state_nxt = S_ISSUE_WR;
        end else begin
          w_fail      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_timing && (w_state_nxt == r_state) && (r_tmo == c_TMO_LAST)) begin
      w_fail      = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  // Per-state handshake trackers and watchdog, all cleared on every state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo      <= '0;
      r_seen_low <= 1'b0;
      r_cap_done <= 1'b0;
    end else if (w_state_chg) begin
      r_tmo      <= '0;
      r_seen_low <= 1'b0;
      r_cap_done <= 1'b0;
    end else begin
      if (w_timing) begin
        r_tmo <= r_tmo + c_TMO_W'(1);
      end
      if (!drv_ready) begin
        r_seen_low <= 1'b1;
      end
      if (drv_rd_valid && (r_state == S_WAIT_RD)) begin
        r_cap_done <= 1'b1;
      end
    end
  end

  // Current command, retry count and captured readback value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_code  <= 8'h00;
      r_retry_cnt <= '0;
      r_rd_data   <= 8'h00;
    end else begin
      if (w_pop) begin
        r_cur_code  <= r_mem[r_rd_ptr];
        r_retry_cnt <= '0;
      end else if (w_retry) begin
        r_retry_cnt <= r_retry_cnt + c_RTY_W'(1);
      end
      if (drv_rd_valid && (r_state == S_WAIT_RD)) begin
        r_rd_data <= drv_rd_data;
      end
    end
  end

  // Registered strobes, status pulses and the saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drv_en        <= 1'b0;
      r_drv_read      <= 1'b0;
      r_applied_delay <= 8'h00;
      r_applied_valid <= 1'b0;
      r_err           <= 1'b0;
      r_err_count     <= 8'h00;
    end else begin
      r_drv_en        <= w_issue_wr;
      r_drv_read      <= w_issue_rd;
      r_applied_valid <= w_apply;
      r_err           <= w_fail;
      if (w_apply) begin
        r_applied_delay <= r_cur_code;
      end
      if (w_fail && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ds1124_cmd_sequencer.sv
//============================================================================
// Module      : tb_ds1124_cmd_sequencer
// Description : Directed self-checking bench for ds1124_cmd_sequencer with a
//               behavioural delay-driver model (stall, corrupt, mismatch).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ds1124_cmd_sequencer;

  localparam int c_TMO = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_delay = 8'h00;
  logic       cmd_ready;
  logic       drv_ready;
  logic       drv_en;
  logic [7:0] drv_delay;
  logic       drv_read;
  logic [7:0] drv_rd_data;
  logic       drv_rd_valid;
  logic       busy;
  logic [7:0] applied_delay;
  logic       applied_valid;
  logic       err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ds1124_cmd_sequencer #(
    .FIFO_DEPTH (4),
    .VERIFY_EN  (1),
    .MAX_RETRY  (2),
    .TIMEOUT_CYC(c_TMO)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_delay    (cmd_delay),
    .cmd_ready    (cmd_ready),
    .drv_ready    (drv_ready),
    .drv_en       (drv_en),
    .drv_delay    (drv_delay),
    .drv_read     (drv_read),
    .drv_rd_data  (drv_rd_data),
    .drv_rd_valid (drv_rd_valid),
    .busy         (busy),
    .applied_delay(applied_delay),
    .applied_valid(applied_valid),
    .err          (err),
    .err_count    (err_count)
  );

  // Driver model controls
  bit         stall     = 1'b0;
  bit         bad_en    = 1'b0;
  logic [7:0] bad_code  = 8'h33;
  int         mism_left = 0;
  int         busy_cnt  = 0;
  bit         pend_rd   = 1'b0;
  logic [7:0] stored    = 8'h00;
  logic [7:0] rb_val    = 8'h00;

  // Behavioural driver: goes busy for two cycles after each strobe
  initial begin
    drv_ready    = 1'b1;
    drv_rd_valid = 1'b0;
    drv_rd_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      drv_rd_valid = 1'b0;
      if (!rst_n) begin
        busy_cnt = 0;
        pend_rd  = 1'b0;
      end else if (drv_en) begin
        stored    = drv_delay;
        drv_ready = 1'b0;
        busy_cnt  = 2;
      end else if (drv_read) begin
        if (bad_en && stored == bad_code) rb_val = 8'h00;
        else if (mism_left > 0) begin
          rb_val    = ~stored;
          mism_left = mism_left - 1;
        end else rb_val = stored;
        drv_ready = 1'b0;
        busy_cnt  = 2;
        pend_rd   = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
        if (busy_cnt == 0 && pend_rd) begin
          drv_rd_valid = 1'b1;
          drv_rd_data  = rb_val;
          pend_rd      = 1'b0;
        end
      end
      if (stall) drv_ready = 1'b0;
      else if (busy_cnt == 0) drv_ready = 1'b1;
    end
  end

  // Monitor: pulse counters, applied-code log and strobe protocol violations
  int         en_pulses = 0;
  int         rd_pulses = 0;
  int         err_pulses = 0;
  int         proto_viol = 0;
  logic       prev_en = 1'b0;
  logic       prev_rd = 1'b0;
  logic [7:0] applied_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (drv_en === 1'b1) en_pulses++;
      if (drv_read === 1'b1) rd_pulses++;
      if (err === 1'b1) err_pulses++;
      if (applied_valid === 1'b1) applied_q.push_back(applied_delay);
      if (drv_en === 1'b1 && drv_read === 1'b1) proto_viol++;
      if (drv_en === 1'b1 && prev_en === 1'b1) proto_viol++;
      if (drv_read === 1'b1 && prev_rd === 1'b1) proto_viol++;
      prev_en = drv_en;
      prev_rd = drv_read;
    end
  end

  task automatic push_cmd(input logic [7:0] code, output bit accepted);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_delay = code;
    accepted  = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Waits for busy to drop, then one more cycle so the monitor has settled
  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (drv_en !== 1'b0 || drv_read !== 1'b0) begin n_errors++; $display("FAIL reset_strobes: en=%b rd=%b want 0 0", drv_en, drv_read); end
    n_checks++; if (drv_delay !== 8'h00) begin n_errors++; $display("FAIL reset_drv_delay: got %h want 00", drv_delay); end
    n_checks++; if (applied_delay !== 8'h00 || applied_valid !== 1'b0) begin n_errors++; $display("FAIL reset_applied: got %h/%b want 00/0", applied_delay, applied_valid); end
    n_checks++; if (err !== 1'b0 || err_count !== 8'h00) begin n_errors++; $display("FAIL reset_err: got %b/%h want 0/00", err, err_count); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    int en0, rd0, q0;
    bit acc, ok;
    en0 = en_pulses; rd0 = rd_pulses; q0 = applied_q.size();
    push_cmd(8'h5A, acc);
    wait_idle(200, ok);
    n_checks++; if (!acc || !ok) begin n_errors++; $display("FAIL single_handshake: accepted=%b idle=%b want 1 1", acc, ok); end
    n_checks++; if (en_pulses - en0 != 1) begin n_errors++; $display("FAIL single_drv_en: got %0d pulses want 1", en_pulses - en0); end
    n_checks++; if (rd_pulses - rd0 != 1) begin n_errors++; $display("FAIL single_drv_read: got %0d pulses want 1", rd_pulses - rd0); end
    n_checks++; if (applied_q.size() != q0 + 1 || applied_delay !== 8'h5A) begin n_errors++; $display("FAIL single_applied: got %0d pulses code %h want 1 code 5a", applied_q.size() - q0, applied_delay); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] codes [5];
    bit acc [5];
    bit ok;
    int q0;
    codes[0] = 8'h77; codes[1] = 8'h10; codes[2] = 8'h20; codes[3] = 8'h30; codes[4] = 8'h40;
    q0 = applied_q.size();
    stall = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) push_cmd(codes[i], acc[i]);
    // 0x77 sits stalled in the FSM, so the four follow-ups fill the FIFO
    push_cmd(8'h50, acc[0]);
    n_checks++; if (acc[0] !== 1'b0) begin n_errors++; $display("FAIL full_fifth_push: accepted=%b want 0", acc[0]); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL full_cmd_ready: got %b want 0", cmd_ready); end
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (acc[i] !== 1'b1) begin n_errors++; $display("FAIL full_push_%0d: accepted=%b want 1", i, acc[i]); end
    end
    stall = 1'b0;
    wait_idle(400, ok);
    n_checks++; if (!ok || applied_q.size() != q0 + 5) begin n_errors++; $display("FAIL full_count: idle=%b applied=%0d want 5", ok, applied_q.size() - q0); end
    for (int i = 0; i < 5; i++) begin
      if (q0 + i < applied_q.size()) begin
        n_checks++; if (applied_q[q0 + i] !== codes[i]) begin n_errors++; $display("FAIL full_order_%0d: got %h want %h", i, applied_q[q0 + i], codes[i]); end
      end
    end
  endtask

  task automatic test_retry_exhaust();
    int en0, rd0, er0, q0;
    bit acc, ok;
    en0 = en_pulses; rd0 = rd_pulses; er0 = err_pulses; q0 = applied_q.size();
    bad_en = 1'b1;
    push_cmd(8'h33, acc);
    wait_idle(300, ok);
    bad_en = 1'b0;
    n_checks++; if (en_pulses - en0 != 3) begin n_errors++; $display("FAIL retry_writes: got %0d want 3", en_pulses - en0); end
    n_checks++; if (rd_pulses - rd0 != 3) begin n_errors++; $display("FAIL retry_reads: got %0d want 3", rd_pulses - rd0); end
    n_checks++; if (err_pulses - er0 != 1 || err_count !== 8'd1) begin n_errors++; $display("FAIL retry_err: pulses=%0d count=%0d want 1 1", err_pulses - er0, err_count); end
    n_checks++; if (applied_q.size() != q0 || applied_delay !== 8'h40) begin n_errors++; $display("FAIL retry_applied: pulses=%0d code %h want 0 code 40", applied_q.size() - q0, applied_delay); end
  endtask

  task automatic test_mismatch_once();
    int en0, er0, q0;
    bit acc, ok;
    en0 = en_pulses; er0 = err_pulses; q0 = applied_q.size();
    mism_left = 1;
    push_cmd(8'h66, acc);
    wait_idle(300, ok);
    n_checks++; if (en_pulses - en0 != 2) begin n_errors++; $display("FAIL mism_writes: got %0d want 2", en_pulses - en0); end
    n_checks++; if (err_pulses != er0 || err_count !== 8'd1) begin n_errors++; $display("FAIL mism_err: pulses=%0d count=%0d want 0 1", err_pulses - er0, err_count); end
    n_checks++; if (applied_q.size() != q0 + 1 || applied_delay !== 8'h66) begin n_errors++; $display("FAIL mism_applied: pulses=%0d code %h want 1 code 66", applied_q.size() - q0, applied_delay); end
  endtask

  task automatic test_timeout();
    int en0, er0, cyc;
    bit acc, ok, seen;
    en0 = en_pulses; er0 = err_pulses;
    stall = 1'b1;
    repeat (2) @(posedge clk);
    push_cmd(8'h11, acc);
    seen = 1'b0; cyc = 0;
    for (int i = 1; i <= c_TMO + 20; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        seen = 1'b1; cyc = i;
        break;
      end
    end
    @(negedge clk);
    n_checks++; if (!seen || cyc < c_TMO || cyc > c_TMO + 3) begin n_errors++; $display("FAIL tmo_latency: seen=%b after %0d cycles want %0d..%0d", seen, cyc, c_TMO, c_TMO + 3); end
    n_checks++; if (err_count !== 8'd2 || err_pulses - er0 != 1) begin n_errors++; $display("FAIL tmo_err_count: count=%0d pulses=%0d want 2 1", err_count, err_pulses - er0); end
    n_checks++; if (busy !== 1'b0 || en_pulses != en0) begin n_errors++; $display("FAIL tmo_idle: busy=%b writes=%0d want 0 0", busy, en_pulses - en0); end
    stall = 1'b0;
    repeat (2) @(posedge clk);
    push_cmd(8'h22, acc);
    wait_idle(200, ok);
    n_checks++; if (!ok || applied_delay !== 8'h22) begin n_errors++; $display("FAIL tmo_recover: idle=%b code %h want 1 code 22", ok, applied_delay); end
  endtask

  task automatic test_reset_midflight();
    int en0, er0, q0;
    bit acc, seen;
    push_cmd(8'h44, acc);
    push_cmd(8'h45, acc);
    push_cmd(8'h46, acc);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (drv_read === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL rstmid_reach_wait_rd: drv_read seen=%b want 1", seen); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_fifo: busy=%b ready=%b want 0 1", busy, cmd_ready); end
    n_checks++; if (drv_delay !== 8'h00 || applied_delay !== 8'h00 || err_count !== 8'h00) begin n_errors++; $display("FAIL rstmid_regs: delay=%h applied=%h errcnt=%h want 00 00 00", drv_delay, applied_delay, err_count); end
    n_checks++; if (drv_en !== 1'b0 || drv_read !== 1'b0 || applied_valid !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL rstmid_pulses: en=%b rd=%b av=%b err=%b want 0", drv_en, drv_read, applied_valid, err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en0 = en_pulses; er0 = err_pulses; q0 = applied_q.size();
    repeat (15) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || en_pulses != en0 || err_pulses != er0 || applied_q.size() != q0) begin n_errors++; $display("FAIL rstmid_release: busy=%b writes=%0d errs=%0d applied=%0d want 0 0 0 0", busy, en_pulses - en0, err_pulses - er0, applied_q.size() - q0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [3];
    bit acc, ok;
    int q0;
    codes[0] = 8'h01; codes[1] = 8'h02; codes[2] = 8'h03;
    q0 = applied_q.size();
    for (int i = 0; i < 3; i++) push_cmd(codes[i], acc);
    wait_idle(300, ok);
    n_checks++; if (!ok || applied_q.size() != q0 + 3) begin n_errors++; $display("FAIL b2b_count: idle=%b applied=%0d want 3", ok, applied_q.size() - q0); end
    for (int i = 0; i < 3; i++) begin
      if (q0 + i < applied_q.size()) begin
        n_checks++; if (applied_q[q0 + i] !== codes[i]) begin n_errors++; $display("FAIL b2b_order_%0d: got %h want %h", i, applied_q[q0 + i], codes[i]); end
      end
    end
    n_checks++; if (proto_viol != 0) begin n_errors++; $display("FAIL strobe_protocol: got %0d violations want 0", proto_viol); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fifo_full();
    test_retry_exhaust();
    test_mismatch_once();
    test_timeout();
    test_reset_midflight();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
